// File: rtl/mmio_mem_bridge.sv
// mmio_mem_bridge: byte-addressed load/store bridge between the datapath and
// a word-addressed RAM plus a small memory-mapped I/O window.
//
// Window layout (byte offset from IO_BASE):
//   0x00 + 2k  IN k     latched input port (read clears its new-data flag)
//   0x10 + 2k  OUT k    registered output port (store pulses dp_out_stb[k])
//   0x1E       STATUS   [N_IN-1:0] new-data, [8+N_IN-1:8] overrun, [15] bus error
//                       (stores are write-1-to-clear on overrun and bus error)
// Below 2^(RAM_AW+1) bytes and outside the window, accesses go to RAM.
// Every other access, including odd addresses, sets the sticky bus_err.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   memw, memr        store / load request (store wins if both are high)
//   addr_in           byte address
//   dataw_in          store data
//   mem_out           registered load data, one cycle after memr
//   dp_in             input port data, port k at [k*DATA_W +: DATA_W]
//   dp_in_valid       per-port capture pulse
//   dp_out            output port registers, port k at [k*DATA_W +: DATA_W]
//   dp_out_stb        one-cycle pulse after port k is written
//   bus_err           sticky access-error flag
module mmio_mem_bridge #(
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       ADDR_W  = 16,
  parameter int unsigned       RAM_AW  = 10,
  parameter int unsigned       N_IN    = 2,
  parameter int unsigned       N_OUT   = 2,
  parameter logic [ADDR_W-1:0] IO_BASE = 16'h3FE0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    memw,
  input  logic                    memr,
  input  logic [ADDR_W-1:0]       addr_in,
  input  logic [DATA_W-1:0]       dataw_in,
  output logic [DATA_W-1:0]       mem_out,
  input  logic [N_IN*DATA_W-1:0]  dp_in,
  input  logic [N_IN-1:0]         dp_in_valid,
  output logic [N_OUT*DATA_W-1:0] dp_out,
  output logic [N_OUT-1:0]        dp_out_stb,
  output logic                    bus_err
);

  localparam int unsigned RamWords = 2 ** RAM_AW;
  localparam int unsigned ErrBit   = 15;

  // State
  logic [DATA_W-1:0]             ram_q [RamWords];
  logic [DATA_W-1:0]             mem_out_q, mem_out_d;
  logic [N_IN-1:0][DATA_W-1:0]   in_reg_q, in_reg_d;
  logic [N_IN-1:0]               in_new_q, in_new_d;
  logic [N_IN-1:0]               overrun_q, overrun_d;
  logic [N_OUT-1:0][DATA_W-1:0]  dp_out_q, dp_out_d;
  logic [N_OUT-1:0]              stb_q, stb_d;
  logic                          bus_err_q, bus_err_d;

  // Decode
  logic       store, load;
  logic       in_win;
  logic [4:0] off;
  logic [2:0] sel;
  logic       is_in, is_out, is_stat, is_ram, illegal;

  assign store = memw;
  // A simultaneous store takes priority and the load is dropped.
  assign load  = memr & ~memw;

  // The window is 32-byte aligned, so membership is an upper-bit match.
  assign in_win  = (addr_in[ADDR_W-1:5] == IO_BASE[ADDR_W-1:5]);
  assign off     = addr_in[4:0];
  assign sel     = off[3:1];
  assign is_in   = in_win && !off[4] && !off[0] && (32'(sel) < N_IN);
  assign is_out  = in_win && off[4] && !off[0] && (32'(sel) < N_OUT);
  assign is_stat = in_win && (off == 5'd30);
  assign is_ram  = !in_win && !addr_in[0] && ((addr_in >> (RAM_AW + 1)) == '0);
  assign illegal = !(is_in || is_out || is_stat || is_ram);

  // Read data
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    status               = '0;
    status[N_IN-1:0]     = in_new_q;
    status[8 +: N_IN]    = overrun_q;
    status[ErrBit]       = bus_err_q;
  end

  always_comb begin
    rd_data = '0;
    if (is_ram) begin
      rd_data = ram_q[addr_in[RAM_AW:1]];
    end else if (is_stat) begin
      rd_data = status;
    end else if (is_in) begin
      for (int k = 0; k < N_IN; k++) begin
        if (sel == 3'(k)) rd_data = in_reg_q[k];
      end
    end else if (is_out) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (sel == 3'(k)) rd_data = dp_out_q[k];
      end
    end
  end

  // Next state
  logic [N_IN-1:0] w1c_ovr;
  logic [N_IN-1:0] ovr_set;
  logic            clr_new;

  always_comb begin
    mem_out_d = mem_out_q;
    in_reg_d  = in_reg_q;
    in_new_d  = in_new_q;
    dp_out_d  = dp_out_q;
    stb_d     = '0;
    ovr_set   = '0;
    clr_new   = 1'b0;
    w1c_ovr   = (store && is_stat) ? dataw_in[8 +: N_IN] : '0;

    // Illegal loads fall through the read mux as zero.
    if (load) mem_out_d = rd_data;

    for (int k = 0; k < N_IN; k++) begin
      clr_new = load && is_in && (sel == 3'(k));
      if (dp_in_valid[k]) begin
        // A same-cycle read consumes the old value, so the new one is not an overrun.
        in_reg_d[k] = dp_in[k*DATA_W +: DATA_W];
        in_new_d[k] = 1'b1;
        ovr_set[k]  = in_new_q[k] && !clr_new;
      end else if (clr_new) begin
        in_new_d[k] = 1'b0;
      end
    end

    for (int k = 0; k < N_OUT; k++) begin
      if (store && is_out && (sel == 3'(k))) begin
        dp_out_d[k] = dataw_in;
        stb_d[k]    = 1'b1;
      end
    end

    // Clear first, then set, so a new event beats a same-cycle W1C.
    overrun_d = (overrun_q & ~w1c_ovr) | ovr_set;
    bus_err_d = (bus_err_q & ~(store && is_stat && dataw_in[ErrBit]))
              | (illegal && (store || load));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_out_q <= '0;
      in_reg_q  <= '0;
      in_new_q  <= '0;
      overrun_q <= '0;
      dp_out_q  <= '0;
      stb_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      mem_out_q <= mem_out_d;
      in_reg_q  <= in_reg_d;
      in_new_q  <= in_new_d;
      overrun_q <= overrun_d;
      dp_out_q  <= dp_out_d;
      stb_q     <= stb_d;
      bus_err_q <= bus_err_d;
    end
  end

  // RAM contents are not reset, but reset still blocks a same-cycle store.
  always_ff @(posedge CLK) begin
    if (!RST && store && is_ram) ram_q[addr_in[RAM_AW:1]] <= dataw_in;
  end

  assign mem_out    = mem_out_q;
  assign dp_out     = dp_out_q;
  assign dp_out_stb = stb_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mmio_mem_bridge.sv
module tb_mmio_mem_bridge;

  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int BASE  = 'h3FE0;

  localparam int KRam  = 0;
  localparam int KIn   = 1;
  localparam int KOut  = 2;
  localparam int KStat = 3;
  localparam int KIll  = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        memw, memr;
  logic [15:0] addr_in, dataw_in;
  logic [15:0] mem_out;
  logic [31:0] dp_in;
  logic [1:0]  dp_in_valid;
  logic [31:0] dp_out;
  logic [1:0]  dp_out_stb;
  logic        bus_err;

  mmio_mem_bridge dut (
    .CLK         (CLK),
    .RST         (RST),
    .memw        (memw),
    .memr        (memr),
    .addr_in     (addr_in),
    .dataw_in    (dataw_in),
    .mem_out     (mem_out),
    .dp_in       (dp_in),
    .dp_in_valid (dp_in_valid),
    .dp_out      (dp_out),
    .dp_out_stb  (dp_out_stb),
    .bus_err     (bus_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] m_ram [1024];
  logic [15:0] m_in  [N_IN];
  logic [15:0] m_out [N_OUT];
  bit          m_new [N_IN];
  bit          m_ovr [N_IN];
  bit          m_err;
  bit   [1:0]  m_stb;
  logic [15:0] m_mem_out;

  typedef struct packed {
    logic [15:0] mem_out;
    logic [31:0] dp_out;
    logic [1:0]  stb;
    logic        err;
  } snap_t;

  logic [15:0] ld_q [$];
  snap_t       st_q [$];

  function automatic void classify(input logic [15:0] a, output int kind, output int idx);
    int ai;
    int o;
    ai   = int'(a);
    kind = KIll;
    idx  = 0;
    if (ai >= BASE && ai < BASE + 32) begin
      o = ai - BASE;
      if (o % 2 == 0) begin
        if (o < 2 * N_IN) begin
          kind = KIn;
          idx  = o / 2;
        end else if (o >= 16 && o < 16 + 2 * N_OUT) begin
          kind = KOut;
          idx  = (o - 16) / 2;
        end else if (o == 30) begin
          kind = KStat;
        end
      end
    end else if (ai < 2048 && ai % 2 == 0) begin
      kind = KRam;
      idx  = ai / 2;
    end
  endfunction

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0;
    for (int k = 0; k < N_IN; k++) begin
      s[k]     = m_new[k];
      s[8 + k] = m_ovr[k];
    end
    s[15] = m_err;
    return s;
  endfunction

  // Applies one cycle of the access rules to the model; queues any load result.
  task automatic model_step(input bit rst, input bit w, input bit r, input logic [15:0] a,
                            input logic [15:0] wd, input logic [1:0] v, input logic [31:0] din);
    int   kind, idx;
    bit   ld;
    logic [15:0] data;
    bit   clr;
    if (rst) begin
      m_mem_out = 16'h0;
      m_err     = 0;
      m_stb     = 2'b00;
      for (int k = 0; k < N_IN; k++) begin
        m_in[k]  = 16'h0;
        m_new[k] = 0;
        m_ovr[k] = 0;
      end
      for (int k = 0; k < N_OUT; k++) m_out[k] = 16'h0;
      return;
    end
    classify(a, kind, idx);
    ld   = r && !w;
    data = 16'h0;
    if (ld) begin
      case (kind)
        KRam:    data = m_ram[idx];
        KIn:     data = m_in[idx];
        KOut:    data = m_out[idx];
        KStat:   data = m_status();
        default: data = 16'h0;
      endcase
      ld_q.push_back(data);
      m_mem_out = data;
    end
    m_stb = 2'b00;
    if (w) begin
      case (kind)
        KRam: m_ram[idx] = wd;
        KOut: begin
          m_out[idx]   = wd;
          m_stb[idx]   = 1'b1;
        end
        KStat: begin
          for (int k = 0; k < N_IN; k++) if (wd[8 + k]) m_ovr[k] = 0;
          if (wd[15]) m_err = 0;
        end
        default: ;
      endcase
    end
    for (int k = 0; k < N_IN; k++) begin
      clr = ld && kind == KIn && idx == k;
      if (v[k]) begin
        if (m_new[k] && !clr) m_ovr[k] = 1;
        m_in[k]  = din[16*k +: 16];
        m_new[k] = 1;
      end else if (clr) begin
        m_new[k] = 0;
      end
    end
    if (kind == KIll && (w || ld)) m_err = 1;
  endtask

  task automatic step(input bit rst, input bit w, input bit r, input logic [15:0] a,
                      input logic [15:0] wd, input logic [1:0] v, input logic [31:0] din);
    snap_t s;
    RST         = rst;
    memw        = w;
    memr        = r;
    addr_in     = a;
    dataw_in    = wd;
    dp_in_valid = v;
    dp_in       = din;
    model_step(rst, w, r, a, wd, v, din);
    @(posedge CLK);
    s.mem_out = m_mem_out;
    s.dp_out  = {m_out[1], m_out[0]};
    s.stb     = m_stb;
    s.err     = m_err;
    st_q.push_back(s);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 16'h0, 2'b00, 32'h0);
  endtask

  // Monitor: decoupled from the driver, keyed on the load it saw at the edge.
  bit ld_seen = 0;
  always @(posedge CLK) ld_seen <= memr && !memw && !RST;

  always @(negedge CLK) begin
    snap_t s;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      check("mem_out", {16'h0, mem_out}, {16'h0, s.mem_out});
      check("dp_out", dp_out, s.dp_out);
      check("dp_out_stb", {30'h0, dp_out_stb}, {30'h0, s.stb});
      check("bus_err", {31'h0, bus_err}, {31'h0, s.err});
    end
    if (ld_seen) begin
      if (ld_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL load_queue: got unexpected load response, expected none");
      end else begin
        check("load_data", {16'h0, mem_out}, {16'h0, ld_q.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] ram_set [8];
  logic [15:0] ill_set [7];

  function automatic logic [15:0] pick_addr();
    int c;
    c = $urandom_range(0, 15);
    case (c)
      8:       return 16'h3FE0;
      9:       return 16'h3FE2;
      10:      return 16'h3FF0;
      11:      return 16'h3FF2;
      12:      return 16'h3FFE;
      13:      return ill_set[$urandom_range(0, 6)];
      default: return ram_set[c % 8];
    endcase
  endfunction

  initial begin
    ram_set = '{16'h0010, 16'h0000, 16'h0002, 16'h07FE, 16'h0400, 16'h3FDE, 16'h0812 & 16'h07FF,
                16'h0100};
    ill_set = '{16'h0011, 16'h0810, 16'h3FE4, 16'h3FF6, 16'hFFFE, 16'h3FE1, 16'h3FFF};

    // Reset
    step(1, 0, 0, 16'h0, 16'h0, 2'b00, 32'h0);
    step(1, 1, 1, 16'h3FF0, 16'h5A5A, 2'b11, 32'h1111_2222);
    idle();

    // Populate the RAM words used by random loads
    for (int i = 0; i < 8; i++) step(0, 1, 0, ram_set[i], 16'($urandom), 2'b00, 32'h0);

    // 1: RAM round trip, out-of-range store
    step(0, 1, 0, 16'h0010, 16'hBEEF, 2'b00, 32'h0);
    step(0, 0, 1, 16'h0010, 16'h0, 2'b00, 32'h0);
    idle();
    step(0, 1, 0, 16'h0810, 16'h1111, 2'b00, 32'h0);
    step(0, 0, 1, 16'h0010, 16'h0, 2'b00, 32'h0);
    step(0, 1, 0, 16'h3FFE, 16'h8000, 2'b00, 32'h0);

    // 2: output port store and readback
    step(0, 1, 0, 16'h3FF2, 16'h1234, 2'b00, 32'h0);
    idle();
    step(0, 0, 1, 16'h3FF2, 16'h0, 2'b00, 32'h0);
    idle();

    // 3: capture, status, read clears new-data
    step(0, 0, 0, 16'h0, 16'h0, 2'b01, 32'h0000_00AA);
    step(0, 0, 1, 16'h3FFE, 16'h0, 2'b00, 32'h0);
    step(0, 0, 1, 16'h3FE0, 16'h0, 2'b00, 32'h0);
    step(0, 0, 1, 16'h3FFE, 16'h0, 2'b00, 32'h0);

    // 4: overrun on port 1, then W1C
    step(0, 0, 0, 16'h0, 16'h0, 2'b10, 32'h0077_0000);
    step(0, 0, 0, 16'h0, 16'h0, 2'b10, 32'h0088_0000);
    step(0, 0, 1, 16'h3FFE, 16'h0, 2'b00, 32'h0);
    step(0, 1, 0, 16'h3FFE, 16'h0200, 2'b00, 32'h0);
    step(0, 0, 1, 16'h3FFE, 16'h0, 2'b00, 32'h0);

    // 5: load IN0 during a capture
    step(0, 0, 0, 16'h0, 16'h0, 2'b01, 32'h0000_00AA);
    step(0, 0, 1, 16'h3FE0, 16'h0, 2'b01, 32'h0000_0055);
    step(0, 0, 1, 16'h3FFE, 16'h0, 2'b00, 32'h0);
    step(0, 0, 1, 16'h3FE0, 16'h0, 2'b00, 32'h0);

    // 6: odd address load, then reset mid-stream
    step(0, 0, 1, 16'h0011, 16'h0, 2'b00, 32'h0);
    step(0, 1, 1, 16'h3FF0, 16'hCAFE, 2'b00, 32'h0);
    step(1, 1, 0, 16'h3FF2, 16'h4321, 2'b11, 32'h1234_5678);
    step(0, 0, 1, 16'h0010, 16'h0, 2'b00, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit          rst_b, w_b, r_b;
      logic [1:0]  v;
      rst_b = ($urandom_range(0, 63) == 0);
      w_b   = ($urandom_range(0, 2) == 0);
      r_b   = ($urandom_range(0, 1) == 0);
      v     = 2'b00;
      for (int k = 0; k < N_IN; k++) v[k] = ($urandom_range(0, 4) == 0);
      step(rst_b, w_b, r_b, pick_addr(), 16'($urandom), v, $urandom);
    end

    idle();
    idle();
    idle();
    check("load_queue_drained", ld_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
